// File: rtl/base_led_driver.sv
// base_led_driver: decodes the thermometer base-occupancy code onto the three
// diamond base LEDs, blinks the most recently occupied base and flags illegal
// codes while holding the last valid display.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | all occupied bases lit steady, no blink in progress
//   BLINK | base idx_q flashes on iTICK until cnt_q runs out
module base_led_driver #(
    parameter int BLINK_TOGGLES = 6,
    parameter int CNT_W         = 4
) (
    input  logic       iCLK,
    input  logic       iRSTn,
    input  logic       iTICK,
    input  logic [2:0] iBASE_CODE,
    output logic [2:0] oLED,
    output logic       oERR,
    output logic       oBUSY
);

    typedef enum logic {
        IDLE  = 1'b0,
        BLINK = 1'b1
    } state_t;

    logic [2:0]       code_q;
    logic [1:0]       cur_q,   cur_d;
    state_t           state_q, state_d;
    logic [1:0]       idx_q,   idx_d;
    logic             phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             err_q,   err_d;

    logic             code_legal;
    logic [1:0]       code_n;
    logic             code_change;
    logic             tick_run;

    // Thermometer decode of the registered code; anything non-thermometer is illegal.
    always_comb begin
        code_legal = 1'b1;
        code_n     = 2'd0;
        case (code_q)
            3'b000:  code_n = 2'd0;
            3'b001:  code_n = 2'd1;
            3'b011:  code_n = 2'd2;
            3'b111:  code_n = 2'd3;
            default: code_legal = 1'b0;
        endcase
    end

    // A valid change of runner count takes precedence over a coincident tick.
    assign code_change = code_legal && (code_n != cur_q);
    assign tick_run    = (state_q == BLINK) && iTICK && !code_change;

    // Next-state: code changes restart or abort the blink; ticks advance it.
    always_comb begin
        cur_d   = cur_q;
        state_d = state_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        err_d   = !code_legal;

        if (tick_run) begin
            phase_d = ~phase_q;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = IDLE;
            end
        end

        if (code_change) begin
            cur_d   = code_n;
            phase_d = 1'b0;
            if (code_n > cur_q) begin
                // Only the highest new base blinks; lower new bases are lit at once.
                state_d = BLINK;
                idx_d   = 2'(code_n - 2'd1);
                cnt_d   = CNT_W'(BLINK_TOGGLES);
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end
    end

    // Input capture stage.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            code_q <= 3'b000;
        end else begin
            code_q <= iBASE_CODE;
        end
    end

    // Display / blink state registers.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            cur_q   <= 2'd0;
            state_q <= IDLE;
            idx_q   <= 2'd0;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            cur_q   <= cur_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // LED drive from registered state only; the blinking base is dark in phase 0.
    always_comb begin
        oLED = 3'b000;
        for (int i = 0; i < 3; i++) begin
            oLED[i] = (2'(i) < cur_q) &&
                      !((state_q == BLINK) && (idx_q == 2'(i)) && !phase_q);
        end
    end

    assign oBUSY = (state_q == BLINK);
    assign oERR  = err_q;

endmodule
